// File: rtl/c3_custom_issue_ctrl.sv
// Core-side issue controller for the C3 custom SIMD unit: accepts one request,
// pulses it into the unit with enforced spacing, and returns a held writeback.
module c3_custom_issue_ctrl #(
    parameter int         VLEN           = 128,
    parameter logic [4:0] IDLE_RD        = 5'd31,
    parameter int         GAP_CYCLES     = 12,
    parameter int         TIMEOUT_CYCLES = 64,
    parameter int         CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_rd,
    input  logic [2:0]       req_vrd1,
    input  logic [2:0]       req_vrd2,
    input  logic [31:0]      req_data,
    input  logic [VLEN-1:0]  req_vdata1,
    input  logic [VLEN-1:0]  req_vdata2,
    input  logic             req_wb,
    output logic             cu_in_v,
    output logic [4:0]       cu_rd,
    output logic [2:0]       cu_vrd1,
    output logic [2:0]       cu_vrd2,
    output logic [31:0]      cu_in_data,
    output logic [VLEN-1:0]  cu_in_vdata1,
    output logic [VLEN-1:0]  cu_in_vdata2,
    input  logic             cu_out_v,
    input  logic [31:0]      cu_out_data,
    input  logic [VLEN-1:0]  cu_out_vdata1,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic [VLEN-1:0]  wb_vdata1,
    output logic             wb_err,
    output logic             busy,
    output logic [CNT_W-1:0] err_count
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

    state_t           state_q;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [TO_W-1:0]  to_q;
    logic [4:0]       rd_q;
    logic             wb_req_q;
    logic             cu_in_v_q;
    logic [4:0]       cu_rd_q;
    logic [2:0]       cu_vrd1_q, cu_vrd2_q;
    logic [31:0]      cu_data_q;
    logic [VLEN-1:0]  cu_vdata1_q, cu_vdata2_q;
    logic             wb_valid_q, wb_err_q;
    logic [4:0]       wb_rd_q;
    logic [31:0]      wb_data_q;
    logic [VLEN-1:0]  wb_vdata1_q;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    always_comb begin
        gap_d       = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
        err_count_d = (&err_count_q) ? err_count_q : err_count_q + CNT_W'(1);
    end

    // The gap counter is loaded on acceptance so it already reads GAP_CYCLES-1
    // during the issue cycle; acceptance-to-issue is one cycle, giving
    // issue-to-issue spacing of at least GAP_CYCLES.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gap_q       <= '0;
            to_q        <= '0;
            rd_q        <= '0;
            wb_req_q    <= 1'b0;
            cu_in_v_q   <= 1'b0;
            cu_rd_q     <= IDLE_RD;
            cu_vrd1_q   <= '0;
            cu_vrd2_q   <= '0;
            cu_data_q   <= '0;
            cu_vdata1_q <= '0;
            cu_vdata2_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_err_q    <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            wb_vdata1_q <= '0;
            err_count_q <= '0;
        end else begin
            gap_q <= gap_d;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        rd_q        <= req_rd;
                        wb_req_q    <= req_wb;
                        cu_in_v_q   <= 1'b1;
                        cu_rd_q     <= req_rd;
                        cu_vrd1_q   <= req_vrd1;
                        cu_vrd2_q   <= req_vrd2;
                        cu_data_q   <= req_data;
                        cu_vdata1_q <= req_vdata1;
                        cu_vdata2_q <= req_vdata2;
                        gap_q       <= GAP_W'(GAP_CYCLES - 1);
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cu_in_v_q <= 1'b0;
                    cu_rd_q   <= IDLE_RD;
                    to_q      <= '0;
                    state_q   <= wb_req_q ? S_WAIT : S_IDLE;
                end
                S_WAIT: begin
                    // A response on the expiry cycle takes priority over the timeout.
                    if (cu_out_v) begin
                        wb_data_q   <= cu_out_data;
                        wb_vdata1_q <= cu_out_vdata1;
                        wb_err_q    <= 1'b0;
                        wb_rd_q     <= rd_q;
                        wb_valid_q  <= 1'b1;
                        state_q     <= S_WB;
                    end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        wb_data_q   <= '0;
                        wb_vdata1_q <= '0;
                        wb_err_q    <= 1'b1;
                        wb_rd_q     <= rd_q;
                        wb_valid_q  <= 1'b1;
                        err_count_q <= err_count_d;
                        state_q     <= S_WB;
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
                end
                S_WB: begin
                    if (wb_ready) begin
                        wb_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready    = (state_q == S_IDLE) && (gap_q == '0);
    assign busy         = (state_q != S_IDLE);
    assign cu_in_v      = cu_in_v_q;
    assign cu_rd        = cu_rd_q;
    assign cu_vrd1      = cu_vrd1_q;
    assign cu_vrd2      = cu_vrd2_q;
    assign cu_in_data   = cu_data_q;
    assign cu_in_vdata1 = cu_vdata1_q;
    assign cu_in_vdata2 = cu_vdata2_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign wb_vdata1    = wb_vdata1_q;
    assign wb_err       = wb_err_q;
    assign err_count    = err_count_q;

endmodule
